// File: rtl/ov5640_cap_pkg.sv
// Shared types and constants for the OV5640 DVP capture path.
package ov5640_cap_pkg;

  typedef enum logic [1:0] {StIdle, StSkip, StWaitFs, StActive} cap_state_e;

  // RGB565 field positions
  localparam int unsigned RMsb = 15;
  localparam int unsigned RLsb = 11;
  localparam int unsigned GMsb = 10;
  localparam int unsigned GLsb = 5;
  localparam int unsigned BMsb = 4;
  localparam int unsigned BLsb = 0;

  localparam int unsigned HActDefault = 1280;
  localparam int unsigned VActDefault = 720;

  // Coordinate pattern: R = x[4:0], G = y[5:0], B = x[9:5].
  function automatic logic [15:0] test_pattern(input logic [9:0] x, input logic [5:0] y);
    logic [15:0] p;
    p[RMsb:RLsb] = x[4:0];
    p[GMsb:GLsb] = y;
    p[BMsb:BLsb] = x[9:5];
    return p;
  endfunction

endpackage

// File: rtl/dvp_byte_pack.sv
// Pairs DVP bytes into 16-bit words; the first byte of each pair becomes the high byte.
module dvp_byte_pack (
  input  logic        clk_pclk,
  input  logic        camera_rstn,
  input  logic        clear,
  input  logic        byte_en,
  input  logic        line_end,
  input  logic [7:0]  byte_data,
  output logic [15:0] word,
  output logic        word_stb,
  output logic        odd_err
);

  logic       phase_q;
  logic [7:0] hi_q;

  always_ff @(posedge clk_pclk or negedge camera_rstn) begin
    if (!camera_rstn) begin
      phase_q <= 1'b0;
      hi_q    <= '0;
    end else if (clear || line_end) begin
      phase_q <= 1'b0;
    end else if (byte_en) begin
      phase_q <= ~phase_q;
      if (!phase_q) hi_q <= byte_data;
    end
  end

  assign word     = {hi_q, byte_data};
  assign word_stb = byte_en & phase_q;
  // A line ending on a held high byte had an odd byte count.
  assign odd_err  = line_end & phase_q;

endmodule

// File: rtl/ov5640_dvp_capture.sv
// OV5640 DVP capture: syncs config-done, skips settling frames, packs bytes into RGB565 pixels.
// Optional DVP_TEST_PATTERN_EN adds input test_pat_en and a coordinate test-pattern source.
module ov5640_dvp_capture
  import ov5640_cap_pkg::*;
#(
  parameter int unsigned FRAME_SKIP = 10,
  parameter int unsigned H_ACT      = HActDefault,
  parameter int unsigned V_ACT      = VActDefault
) (
  input  logic        clk_pclk,
  input  logic        camera_rstn,
  input  logic        reg_conf_done,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
`ifdef DVP_TEST_PATTERN_EN
  input  logic        test_pat_en,
`endif
  output logic [15:0] pix_data,
  output logic        pix_valid,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic [7:0]  frame_cnt,
  output logic        line_err
);

  localparam int unsigned SkipW = $clog2(FRAME_SKIP + 2);
  localparam int unsigned XW    = $clog2(H_ACT + 1);
  localparam int unsigned YW    = $clog2(V_ACT + 1);

  logic             conf_meta_q, conf_sync_q;
  logic             vsync_q, vsync_qq, href_q, href_qq;
  logic [7:0]       data_q;
  cap_state_e       state_q;
  logic [SkipW-1:0] skip_cnt_q;
  logic [XW-1:0]    x_q;
  logic [YW-1:0]    y_q;

  logic        fs, href_fall, active, byte_en, pack_clear, line_end;
  logic        word_stb, odd_err;
  logic [15:0] word, pixel;

  always_ff @(posedge clk_pclk or negedge camera_rstn) begin
    if (!camera_rstn) begin
      conf_meta_q <= 1'b0;
      conf_sync_q <= 1'b0;
      vsync_q     <= 1'b0;
      vsync_qq    <= 1'b0;
      href_q      <= 1'b0;
      href_qq     <= 1'b0;
      data_q      <= '0;
    end else begin
      conf_meta_q <= reg_conf_done;
      conf_sync_q <= conf_meta_q;
      vsync_q     <= cam_vsync;
      vsync_qq    <= vsync_q;
      href_q      <= cam_href;
      href_qq     <= href_q;
      data_q      <= cam_data;
    end
  end

  assign fs         = vsync_q & ~vsync_qq;
  assign href_fall  = ~href_q & href_qq;
  assign active     = (state_q == StActive) & conf_sync_q;
  assign byte_en    = active & href_q & ~fs;
  assign pack_clear = ~active | fs;
  assign line_end   = active & href_fall & ~fs;

  dvp_byte_pack u_pack (
    .clk_pclk    (clk_pclk),
    .camera_rstn (camera_rstn),
    .clear       (pack_clear),
    .byte_en     (byte_en),
    .line_end    (line_end),
    .byte_data   (data_q),
    .word        (word),
    .word_stb    (word_stb),
    .odd_err     (odd_err)
  );

`ifdef DVP_TEST_PATTERN_EN
  assign pixel = test_pat_en ? test_pattern(10'(x_q), 6'(y_q)) : word;
`else
  assign pixel = word;
`endif

  always_ff @(posedge clk_pclk or negedge camera_rstn) begin
    if (!camera_rstn) begin
      state_q    <= StIdle;
      skip_cnt_q <= '0;
      x_q        <= '0;
      y_q        <= '0;
      frame_cnt  <= '0;
      line_err   <= 1'b0;
      pix_data   <= '0;
      pix_valid  <= 1'b0;
      pix_sof    <= 1'b0;
      pix_eol    <= 1'b0;
    end else begin
      pix_valid <= 1'b0;
      pix_sof   <= 1'b0;
      pix_eol   <= 1'b0;
      // Losing configuration wins over everything, including a coincident frame start.
      if (!conf_sync_q) begin
        state_q <= StIdle;
        x_q     <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            state_q    <= StSkip;
            skip_cnt_q <= '0;
          end
          StSkip: begin
            if (skip_cnt_q == SkipW'(FRAME_SKIP)) state_q <= StWaitFs;
            else if (fs) skip_cnt_q <= skip_cnt_q + 1'b1;
          end
          StWaitFs: begin
            if (fs) begin
              state_q   <= StActive;
              frame_cnt <= frame_cnt + 8'd1;
              x_q       <= '0;
              y_q       <= '0;
            end
          end
          StActive: begin
            if (fs) begin
              frame_cnt <= frame_cnt + 8'd1;
              x_q       <= '0;
              y_q       <= '0;
              if (href_q) line_err <= 1'b1;
            end else if (line_end) begin
              if (odd_err) line_err <= 1'b1;
              x_q <= '0;
              if (x_q != '0 && y_q < YW'(V_ACT)) y_q <= y_q + 1'b1;
            end else if (word_stb) begin
              if (x_q >= XW'(H_ACT)) begin
                line_err <= 1'b1;
              end else if (y_q < YW'(V_ACT)) begin
                pix_valid <= 1'b1;
                pix_data  <= pixel;
                pix_sof   <= (x_q == '0) && (y_q == '0);
                pix_eol   <= (x_q == XW'(H_ACT - 1));
                x_q       <= x_q + 1'b1;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ov5640_dvp_capture.sv
// Self-checking bench for ov5640_dvp_capture with a frame/line-level expectation model.
module tb_ov5640_dvp_capture;

  localparam int Fs    = 2;
  localparam int Ha    = 4;
  localparam int Va    = 2;
  localparam int Never = 32'h7fff_ffff;

  logic        clk = 1'b0;
  logic        camera_rstn;
  logic        reg_conf_done;
  logic        cam_vsync;
  logic        cam_href;
  logic [7:0]  cam_data;
  logic [15:0] pix_data;
  logic        pix_valid, pix_sof, pix_eol, line_err;
  logic [7:0]  frame_cnt;

  ov5640_dvp_capture #(
    .FRAME_SKIP (Fs),
    .H_ACT      (Ha),
    .V_ACT      (Va)
  ) dut (
    .clk_pclk      (clk),
    .camera_rstn   (camera_rstn),
    .reg_conf_done (reg_conf_done),
    .cam_vsync     (cam_vsync),
    .cam_href      (cam_href),
    .cam_data      (cam_data),
`ifdef DVP_TEST_PATTERN_EN
    .test_pat_en   (1'b0),
`endif
    .pix_data      (pix_data),
    .pix_valid     (pix_valid),
    .pix_sof       (pix_sof),
    .pix_eol       (pix_eol),
    .frame_cnt     (frame_cnt),
    .line_err      (line_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc++;

  // Model state: expected pixel events keyed by the cycle they must appear in.
  logic [17:0] exp_pix [int];
  int          err_cyc    = Never;
  logic [7:0]  fc_prev    = 8'd0;
  logic [7:0]  fc_new     = 8'd0;
  int          fc_cyc     = 0;
  int          frames_seen = 0;
  bit          out_frame  = 1'b0;
  bit          conf_on    = 1'b0;
  int          drop_lim   = Never;
  int          mx = 0, my = 0;

  logic [7:0]  lb [0:15];
  int          byte_cyc [0:15];
  int          n_valid = 0, n_sof = 0, n_eol = 0;
  logic [15:0] got_data [$];
  int          got_cyc [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    logic [7:0] efc;
    #1;
    efc = (cyc >= fc_cyc) ? fc_new : fc_prev;
    if (exp_pix.exists(cyc))
      chk("pixel", {13'd0, pix_valid, pix_sof, pix_eol, pix_data}, {13'd0, 1'b1, exp_pix[cyc]});
    else
      chk("idle", {29'd0, pix_valid, pix_sof, pix_eol}, 32'd0);
    chk("frame_cnt", {24'd0, frame_cnt}, {24'd0, efc});
    chk("line_err", {31'd0, line_err}, {31'd0, (cyc >= err_cyc)});
    if (pix_valid) begin
      n_valid++;
      got_data.push_back(pix_data);
      got_cyc.push_back(cyc);
    end
    if (pix_sof) n_sof++;
    if (pix_eol) n_eol++;
  end

  function automatic bit live(input int k);
    return out_frame && (k <= drop_lim);
  endfunction

  task automatic set_err(input int k);
    if (k < err_cyc) err_cyc = k;
  endtask

  task automatic conf_up();
    @(negedge clk);
    reg_conf_done = 1'b1;
    conf_on       = 1'b1;
    drop_lim      = Never;
    frames_seen   = 0;
    repeat (6) @(negedge clk);
  endtask

  task automatic frame_start();
    @(negedge clk);
    cam_vsync = 1'b1;
    frames_seen++;
    out_frame = conf_on && (frames_seen > Fs);
    if (out_frame) begin
      fc_prev = (cyc >= fc_cyc) ? fc_new : fc_prev;
      fc_new  = fc_prev + 8'd1;
      fc_cyc  = cyc + 2;
    end
    mx = 0;
    my = 0;
    repeat (3) @(negedge clk);
    cam_vsync = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic fill_line(input int f, input int l, input int n);
    for (int i = 0; i < n; i++) lb[i] = 8'(f * 37 + l * 11 + i * 5 + 3);
  endtask

  task automatic do_reset();
    camera_rstn = 1'b0;
    cam_href    = 1'b0;
    cam_data    = 8'd0;
    exp_pix.delete();
    fc_prev = 8'd0; fc_new = 8'd0; fc_cyc = 0;
    err_cyc = Never;
    frames_seen = 0; out_frame = 1'b0; mx = 0; my = 0;
    #1;
    chk("rst_mid_valid", {31'd0, pix_valid}, 32'd0);
    chk("rst_mid_data", {16'd0, pix_data}, 32'd0);
    chk("rst_mid_fcnt", {24'd0, frame_cnt}, 32'd0);
    chk("rst_mid_err", {31'd0, line_err}, 32'd0);
    repeat (3) @(negedge clk);
    camera_rstn = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  // kind 1: assert reset before byte abort_at; kind 2: drop config before byte abort_at.
  task automatic send_line(input int nbytes, input int abort_at, input int kind);
    for (int i = 0; i < nbytes; i++) begin
      @(negedge clk);
      if (i == abort_at && kind == 1) begin
        do_reset();
        return;
      end
      if (i == abort_at && kind == 2) begin
        reg_conf_done = 1'b0;
        conf_on       = 1'b0;
        drop_lim      = cyc + 2;
      end
      cam_href    = 1'b1;
      cam_data    = lb[i];
      byte_cyc[i] = cyc;
      if (i % 2 == 1 && live(cyc + 2) && my < Va) begin
        if (mx < Ha) begin
          exp_pix[cyc + 2] = {(mx == 0 && my == 0), (mx == Ha - 1), lb[i - 1], lb[i]};
          mx++;
        end else begin
          set_err(cyc + 2);
        end
      end
    end
    @(negedge clk);
    cam_href = 1'b0;
    cam_data = 8'd0;
    if (live(cyc + 2)) begin
      if (nbytes % 2 == 1) set_err(cyc + 2);
      if (mx > 0 && my < Va) my++;
    end
    mx = 0;
    if (!conf_on) out_frame = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, s0, e0, g0;
    camera_rstn = 1'b0; reg_conf_done = 1'b0;
    cam_vsync = 1'b0; cam_href = 1'b0; cam_data = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_valid", {31'd0, pix_valid}, 32'd0);
    chk("rst_sof_eol", {30'd0, pix_sof, pix_eol}, 32'd0);
    chk("rst_data", {16'd0, pix_data}, 32'd0);
    chk("rst_fcnt", {24'd0, frame_cnt}, 32'd0);
    chk("rst_err", {31'd0, line_err}, 32'd0);
    camera_rstn = 1'b1;
    repeat (3) @(negedge clk);
    conf_up();

    // Skip two frames, then two output frames of 4x2; frame 4 line 0 carries pure red/green.
    v0 = n_valid;
    for (int f = 1; f <= 4; f++) begin
      s0 = n_sof; e0 = n_eol;
      if (f == 3) v0 = n_valid;
      frame_start();
      for (int l = 0; l < 2; l++) begin
        fill_line(f, l, 8);
        g0 = got_data.size();
        if (f == 4 && l == 0) begin
          lb[0] = 8'hF8; lb[1] = 8'h00; lb[2] = 8'h07; lb[3] = 8'hE0;
        end
        send_line(8, -1, 0);
        if (f == 4 && l == 0) begin
          chk("red_px", {16'd0, got_data[g0]}, 32'h0000_F800);
          chk("green_px", {16'd0, got_data[g0 + 1]}, 32'h0000_07E0);
          chk("red_lat", got_cyc[g0] - byte_cyc[1], 32'd2);
          chk("green_lat", got_cyc[g0 + 1] - byte_cyc[3], 32'd2);
        end
      end
      if (f == 2) chk("skip_silent", n_valid - v0, 32'd0);
      if (f == 3) begin
        chk("f3_valids", n_valid - v0, 32'd8);
        chk("f3_sof", n_sof - s0, 32'd1);
        chk("f3_eol", n_eol - e0, 32'd2);
        chk("f3_fcnt", {24'd0, frame_cnt}, 32'd1);
      end
    end
    chk("f4_fcnt", {24'd0, frame_cnt}, 32'd2);

    // Odd-length line, then a clean line that must pair from its first byte.
    frame_start();
    fill_line(5, 0, 7);
    v0 = n_valid;
    send_line(7, -1, 0);
    chk("odd_valids", n_valid - v0, 32'd3);
    chk("odd_err", {31'd0, line_err}, 32'd1);
    for (int i = 0; i < 8; i++) lb[i] = 8'((i + 1) * 8'h11);
    g0 = got_data.size(); e0 = n_eol;
    send_line(8, -1, 0);
    chk("repair_px", {16'd0, got_data[g0]}, 32'h0000_1122);
    chk("repair_eol", n_eol - e0, 32'd1);

    // Reset mid-line; skipping restarts afterwards.
    frame_start();
    chk("pre_rst_fcnt", {24'd0, frame_cnt}, 32'd4);
    chk("pre_rst_err", {31'd0, line_err}, 32'd1);
    fill_line(6, 0, 8);
    send_line(8, 3, 1);
    v0 = n_valid;
    for (int f = 1; f <= 2; f++) begin
      frame_start();
      fill_line(f + 10, 0, 8);
      send_line(8, -1, 0);
    end
    chk("reskip_silent", n_valid - v0, 32'd0);

    // Over-long line: 6 pixels against H_ACT=4.
    frame_start();
    fill_line(20, 0, 12);
    v0 = n_valid; s0 = n_sof; e0 = n_eol;
    send_line(12, -1, 0);
    chk("long_valids", n_valid - v0, 32'd4);
    chk("long_eol", n_eol - e0, 32'd1);
    chk("long_sof", n_sof - s0, 32'd1);
    chk("long_err", {31'd0, line_err}, 32'd1);
    chk("long_fcnt", {24'd0, frame_cnt}, 32'd1);

    // Config drop mid-line: output stops, frame_cnt holds.
    frame_start();
    fill_line(21, 0, 8);
    v0 = n_valid;
    send_line(8, 4, 2);
    repeat (10) @(negedge clk);
    chk("drop_valids", n_valid - v0, 32'd2);
    chk("drop_fcnt", {24'd0, frame_cnt}, 32'd2);
    frame_start();
    fill_line(22, 0, 8);
    send_line(8, -1, 0);
    chk("drop_still", n_valid - v0, 32'd2);
    chk("drop_fcnt_hold", {24'd0, frame_cnt}, 32'd2);

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
